i2c_read_sequencer: RTL and testbench
=====================================

// Module: i2c_read_sequencer
// PURPOSE
//  Transaction sequencer that sits directly upstream of the I2C master. It drives the
//  master's address/register/mode/en/Start/Stop/repeat_start controls and performs one
//  complete single-byte register read:
//    S, ADDR+W, REG, Sr, ADDR+R, DATA, P.
//  Reads run periodically or on request. The block captures the master's out byte and
//  reports a NACK or timeout as an error.
// PARAMETERS
//  DEV_ADDR   7'b1110000    7-bit slave address placed on i2c_address
//  REG_ADDR   8'b10110010   register pointer placed on i2c_register
//  PERIOD     20'd100000    clk cycles between automatic reads; 0 disables auto mode
//  TIMEOUT    16'd4000      max clk cycles spent in any one wait state before abort
//  STOP_CYC   8'd20         clk cycles that i2c_stop is held high
// PORTS
//  clk               in   1  system clock, all logic on rising edge
//  reset             in   1  asynchronous reset, active-low
//  enable            in   1  1 = sequencer active; 0 = stays/returns to IDLE after current P
//  trig              in   1  one-cycle read request
//  i2c_ack           in   1  from master: one-cycle pulse, slave ACKed the last byte
//  i2c_nack          in   1  from master: one-cycle pulse, slave NACKed the last byte
//  i2c_rdy           in   1  from master: one-cycle pulse, read byte valid on i2c_out
//  i2c_out           in   8  from master: received data byte
//  i2c_address       out  7  to master: slave address (constant DEV_ADDR)
//  i2c_register      out  8  to master: register pointer (constant REG_ADDR)
//  i2c_mode          out  1  to master: 0 = write phase, 1 = read phase
//  i2c_en            out  1  to master: enable, high from S through P
//  i2c_start         out  1  to master: Start request level
//  i2c_repeat_start  out  1  to master: repeated-start request level
//  i2c_stop          out  1  to master: Stop request level
//  data_out          out  8  last successfully read byte
//  data_valid        out  1  one-cycle pulse when data_out updates
//  err               out  1  one-cycle pulse on NACK or timeout
//  busy              out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset (reset==0, asynchronous):
//   - state = IDLE; all outputs 0, except i2c_address=DEV_ADDR and i2c_register=REG_ADDR.
//   - Period counter = PERIOD; pending flag cleared; timeout counter = 0.
//  Launch:
//   - In IDLE with enable=1, a launch occurs when pending=1, or trig=1, or the period
//     counter reaches 0.
//   - The period counter decrements every cycle while enable=1, reloads on launch, and
//     holds while busy.
//  Pending flag:
//   - Set by trig while busy; one-deep, extra trigs are dropped.
//   - Cleared on launch.
//  States and outputs:
//   - IDLE:   all control outputs 0. On launch -> ADDR_W.
//   - ADDR_W: en=1, start=1, mode=0. i2c_ack -> REG_W.
//   - REG_W:  en=1, start=0, mode=0. i2c_ack -> RSTART.
//   - RSTART: en=1, repeat_start=1, mode=1. Single cycle -> ADDR_R.
//   - ADDR_R: en=1, repeat_start=1, mode=1. i2c_ack -> READ (repeat_start drops).
//   - READ:   en=1, mode=1. i2c_rdy -> capture i2c_out into data_out, pulse data_valid
//             (same edge as the capture), -> STOP.
//   - STOP:   en=1, stop=1 for STOP_CYC cycles, then -> IDLE with en=0.
//  Error handling:
//   - i2c_nack in any of ADDR_W/REG_W/ADDR_R/READ: pulse err, go to STOP, data_out
//     unchanged.
//   - Timeout: the timeout counter clears on every state entry and increments in the wait
//     states. At TIMEOUT-1: pulse err, go to STOP.
//   - i2c_ack and i2c_nack in the same cycle: treated as NACK.
//  Edge cases:
//   - i2c_ack/i2c_rdy pulses in IDLE or STOP are ignored.
//   - enable dropping mid-transaction does not abort; the transaction completes through P,
//     then the block stays in IDLE.
//   - reset asserted mid-transaction: immediate return to the reset values.
//  Latency: data_valid occurs 1 clk after the i2c_rdy pulse.
// TESTING
//  1. PERIOD=0, trig at t0 with ack,ack,ack,rdy and i2c_out=8'hF0
//     -> control sequence start / repeat_start / stop as specified, data_out=8'hF0,
//        one data_valid pulse, err=0, busy drops after STOP_CYC.
//  2. trig, then i2c_nack in REG_W
//     -> err pulses once, stop held 20 cycles, data_out keeps the previous 8'hF0,
//        no data_valid.
//  3. trig, no responses
//     -> err at exactly TIMEOUT cycles after ADDR_W entry, then STOP, then IDLE.
//  4. PERIOD=50, enable=1, ideal responder
//     -> launches every 50 clk of IDLE time; 3 reads produce 3 data_valid pulses.
//  5. trig x3 while busy
//     -> exactly one extra transaction follows; enable=0 mid-read still completes
//        with data_valid.
//  6. reset low during READ
//     -> all outputs go to reset values asynchronously, pending cleared, no data_valid.

Source files
------------

// File: rtl/i2c_read_sequencer_if.sv
// Bundle between the read sequencer and its neighbours: the I2C master controls and
// responses, plus the user-facing request and result signals.
interface i2c_read_sequencer_if;
   logic       enable;
   logic       trig;
   logic       i2c_ack;
   logic       i2c_nack;
   logic       i2c_rdy;
   logic [7:0] i2c_out;
   logic [6:0] i2c_address;
   logic [7:0] i2c_register;
   logic       i2c_mode;
   logic       i2c_en;
   logic       i2c_start;
   logic       i2c_repeat_start;
   logic       i2c_stop;
   logic [7:0] data_out;
   logic       data_valid;
   logic       err;
   logic       busy;

   modport master (
      input  enable, trig, i2c_ack, i2c_nack, i2c_rdy, i2c_out,
      output i2c_address, i2c_register, i2c_mode, i2c_en, i2c_start,
             i2c_repeat_start, i2c_stop, data_out, data_valid, err, busy
   );

   modport slave (
      output enable, trig, i2c_ack, i2c_nack, i2c_rdy, i2c_out,
      input  i2c_address, i2c_register, i2c_mode, i2c_en, i2c_start,
             i2c_repeat_start, i2c_stop, data_out, data_valid, err, busy
   );
endinterface

// File: rtl/i2c_read_sequencer.sv
// Drives an I2C master through S, ADDR+W, REG, Sr, ADDR+R, DATA, P for one register
// byte, periodically or on request, and reports NACK/timeout as a one-cycle error.
module i2c_read_sequencer #(
   parameter logic [6:0]  DEV_ADDR = 7'b1110000,
   parameter logic [7:0]  REG_ADDR = 8'b10110010,
   parameter logic [19:0] PERIOD   = 20'd100000,
   parameter logic [15:0] TIMEOUT  = 16'd4000,
   parameter logic [7:0]  STOP_CYC = 8'd20
) (
   input logic                  clk,
   input logic                  reset,
   i2c_read_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR_W, S_REG_W, S_RSTART, S_ADDR_R, S_READ, S_STOP
   } state_t;

   localparam logic [15:0] TMO_LAST  = TIMEOUT - 16'd1;
   localparam logic [15:0] STOP_LAST = {8'h00, STOP_CYC} - 16'd1;

   state_t      state_q, state_d;
   logic [19:0] per_q, per_d;
   logic [15:0] cnt_q, cnt_d;
   logic        pend_q, pend_d;
   logic [7:0]  data_q, data_d;
   logic        dv_q, dv_d;
   logic        err_q, err_d;
   logic        en_q, en_d;
   logic        start_q, start_d;
   logic        rs_q, rs_d;
   logic        stop_q, stop_d;
   logic        mode_q, mode_d;
   logic        busy_q, busy_d;
   logic        launch, per_hit, tmo;

   always_comb begin
      state_d = state_q;
      per_d   = per_q;
      pend_d  = pend_q;
      data_d  = data_q;
      dv_d    = 1'b0;
      err_d   = 1'b0;
      // Launch on the cycle the countdown would reach zero, giving PERIOD idle cycles.
      per_hit = (PERIOD != '0) && (per_q <= 20'd1);
      launch  = (state_q == S_IDLE) && bus.enable && (pend_q || bus.trig || per_hit);
      tmo     = (cnt_q == TMO_LAST);

      case (state_q)
         S_IDLE:   if (launch) state_d = S_ADDR_W;
         S_ADDR_W, S_REG_W, S_ADDR_R: begin
            if (bus.i2c_nack) begin
               err_d   = 1'b1;
               state_d = S_STOP;
            end else if (bus.i2c_ack) begin
               case (state_q)
                  S_ADDR_W: state_d = S_REG_W;
                  S_REG_W:  state_d = S_RSTART;
                  default:  state_d = S_READ;
               endcase
            end else if (tmo) begin
               err_d   = 1'b1;
               state_d = S_STOP;
            end
         end
         S_RSTART: state_d = S_ADDR_R;
         S_READ: begin
            if (bus.i2c_nack) begin
               err_d   = 1'b1;
               state_d = S_STOP;
            end else if (bus.i2c_rdy) begin
               data_d  = bus.i2c_out;
               dv_d    = 1'b1;
               state_d = S_STOP;
            end else if (tmo) begin
               err_d   = 1'b1;
               state_d = S_STOP;
            end
         end
         S_STOP:   if (cnt_q == STOP_LAST) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      // One counter serves both the wait-state timeout and the Stop hold time.
      if ((state_d != state_q) || (state_q == S_IDLE)) cnt_d = '0;
      else                                             cnt_d = cnt_q + 16'd1;

      if (launch)
         per_d = PERIOD;
      else if ((state_q == S_IDLE) && bus.enable && (per_q != '0))
         per_d = per_q - 20'd1;

      if (launch)                                 pend_d = 1'b0;
      else if ((state_q != S_IDLE) && bus.trig)   pend_d = 1'b1;

      en_d    = (state_d != S_IDLE);
      busy_d  = (state_d != S_IDLE);
      start_d = (state_d == S_ADDR_W);
      rs_d    = (state_d == S_RSTART) || (state_d == S_ADDR_R);
      stop_d  = (state_d == S_STOP);
      mode_d  = (state_d == S_RSTART) || (state_d == S_ADDR_R) || (state_d == S_READ);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         per_q   <= PERIOD;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         data_q  <= '0;
         dv_q    <= 1'b0;
         err_q   <= 1'b0;
         en_q    <= 1'b0;
         start_q <= 1'b0;
         rs_q    <= 1'b0;
         stop_q  <= 1'b0;
         mode_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         per_q   <= per_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         data_q  <= data_d;
         dv_q    <= dv_d;
         err_q   <= err_d;
         en_q    <= en_d;
         start_q <= start_d;
         rs_q    <= rs_d;
         stop_q  <= stop_d;
         mode_q  <= mode_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.i2c_address      = DEV_ADDR;
   assign bus.i2c_register     = REG_ADDR;
   assign bus.i2c_mode         = mode_q;
   assign bus.i2c_en           = en_q;
   assign bus.i2c_start        = start_q;
   assign bus.i2c_repeat_start = rs_q;
   assign bus.i2c_stop         = stop_q;
   assign bus.data_out         = data_q;
   assign bus.data_valid       = dv_q;
   assign bus.err              = err_q;
   assign bus.busy             = busy_q;

endmodule

// File: tb/tb_i2c_read_sequencer.sv
// Scoreboard bench: stimulus queues responder scripts and expected results; monitors
// compare data/err pulses and per-transaction control sequences as they appear.
module tb_i2c_read_sequencer;

   logic clk  = 1'b0;
   logic rst0 = 1'b1;
   logic rst1 = 1'b1;
   always #5 clk = ~clk;

   i2c_read_sequencer_if b0 ();
   i2c_read_sequencer_if b1 ();

   i2c_read_sequencer #(.PERIOD(20'd0))  dut0 (.clk(clk), .reset(rst0), .bus(b0));
   i2c_read_sequencer #(.PERIOD(20'd50)) dut1 (.clk(clk), .reset(rst1), .bus(b1));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef enum int {R_OK, R_NACK_REG, R_SILENT, R_BOTH_ADDR} rmode_t;
   typedef struct { rmode_t mode; logic [7:0] data; } rsp_t;
   typedef struct { logic is_err; logic [7:0] data; } ev_t;
   typedef struct { int n; logic [4:0][4:0] w; int stop_len; } seq_t;

   rsp_t       rsp_q[$];
   ev_t        ev0_q[$];
   logic [7:0] ev1_q[$];
   seq_t       seq_q[$];

   // Control word {en, start, repeat_start, stop, mode}; mode is masked while stop=1.
   localparam logic [4:0] W_AW = 5'b11000;
   localparam logic [4:0] W_RW = 5'b10000;
   localparam logic [4:0] W_RS = 5'b10101;
   localparam logic [4:0] W_RD = 5'b10001;
   localparam logic [4:0] W_ST = 5'b10010;

   function automatic seq_t mk_seq(input int n, input logic [4:0] a, input logic [4:0] b,
                                   input logic [4:0] c, input logic [4:0] d,
                                   input logic [4:0] e, input int sl);
      seq_t s;
      s.n = n;
      s.w = {e, d, c, b, a};
      s.stop_len = sl;
      return s;
   endfunction

   function automatic logic [4:0] ctrl0();
      return {b0.i2c_en, b0.i2c_start, b0.i2c_repeat_start, b0.i2c_stop,
              b0.i2c_mode & ~b0.i2c_stop};
   endfunction

   task automatic p0(input logic a, input logic n, input logic r);
      b0.i2c_ack = a; b0.i2c_nack = n; b0.i2c_rdy = r;
      @(negedge clk);
      b0.i2c_ack = 1'b0; b0.i2c_nack = 1'b0; b0.i2c_rdy = 1'b0;
   endtask

   task automatic p1(input logic a, input logic r);
      b1.i2c_ack = a; b1.i2c_rdy = r;
      @(negedge clk);
      b1.i2c_ack = 1'b0; b1.i2c_rdy = 1'b0;
   endtask

   // Responder for dut0, scripted per transaction from rsp_q.
   initial begin : resp0
      rsp_t r;
      forever begin
         @(negedge clk);
         if (b0.i2c_start === 1'b1) begin
            r = (rsp_q.size() != 0) ? rsp_q.pop_front() : '{R_SILENT, 8'h00};
            if (r.mode != R_SILENT) begin
               @(negedge clk);
               if (r.mode == R_BOTH_ADDR) p0(1'b1, 1'b1, 1'b0);
               else                       p0(1'b1, 1'b0, 1'b0);
               if (r.mode == R_NACK_REG) begin
                  @(negedge clk); p0(1'b0, 1'b1, 1'b0);
               end else if (r.mode == R_OK) begin
                  @(negedge clk); p0(1'b1, 1'b0, 1'b0);
                  @(negedge clk); p0(1'b1, 1'b0, 1'b0);
                  @(negedge clk); b0.i2c_out = r.data; p0(1'b0, 1'b0, 1'b1);
               end
            end
            while (b0.i2c_en === 1'b1) @(negedge clk);
         end
      end
   end

   // Ideal responder for dut1 with incrementing data.
   initial begin : resp1
      logic [7:0] d1;
      d1 = 8'hA0;
      forever begin
         @(negedge clk);
         if (b1.i2c_start === 1'b1) begin
            @(negedge clk); p1(1'b1, 1'b0);
            @(negedge clk); p1(1'b1, 1'b0);
            @(negedge clk); p1(1'b1, 1'b0);
            @(negedge clk); b1.i2c_out = d1; p1(1'b0, 1'b1);
            d1 = d1 + 8'h01;
            while (b1.i2c_en === 1'b1) @(negedge clk);
         end
      end
   end

   always @(negedge clk) begin : mon0
      ev_t e;
      if (rst0 && (b0.data_valid || b0.err)) begin
         if (ev0_q.size() == 0) begin
            chk("unexpected_dv_err", {30'd0, b0.err, b0.data_valid}, 32'd0);
         end else begin
            e = ev0_q.pop_front();
            chk("event_kind", {30'd0, b0.err, b0.data_valid}, e.is_err ? 32'd2 : 32'd1);
            chk("data_out", {24'd0, b0.data_out}, {24'd0, e.data});
         end
      end
   end

   int dv1_cnt  = 0;
   int err1_cnt = 0;
   always @(negedge clk) begin : mon1
      if (rst1 && b1.data_valid) begin
         dv1_cnt++;
         if (ev1_q.size() == 0) chk("unexpected_dv1", {31'd0, b1.data_valid}, 32'd0);
         else                   chk("dut1_data_out", {24'd0, b1.data_out}, {24'd0, ev1_q.pop_front()});
      end
      if (rst1 && b1.err) err1_cnt++;
   end

   // Records distinct control words per transaction and checks them when en falls.
   always @(negedge clk) begin : seqmon
      static logic [4:0] last = '0;
      static seq_t       cur  = '{0, '0, 0};
      seq_t              e;
      logic [4:0]        w;
      w = ctrl0();
      if (w != '0) begin
         if (w != last) begin
            if (cur.n < 5) cur.w[cur.n] = w;
            cur.n++;
         end
         if (w[1]) cur.stop_len++;
      end else if (last != '0) begin
         if (seq_q.size() == 0) begin
            chk("unexpected_txn", cur.n, 32'd0);
         end else begin
            e = seq_q.pop_front();
            chk("ctrl_seq_len", cur.n, e.n);
            chk("ctrl_seq", {7'd0, cur.w}, {7'd0, e.w});
            chk("stop_cycles", cur.stop_len, e.stop_len);
         end
         cur = '{0, '0, 0};
      end
      last = w;
   end

   task automatic trig0();
      b0.trig = 1'b1;
      @(negedge clk);
      b0.trig = 1'b0;
   endtask

   task automatic wait_idle0(input int budget);
      int c = 0;
      while (b0.busy && c < budget) begin @(negedge clk); c++; end
      chk("wait_idle0", {31'd0, b0.busy}, 32'd0);
   endtask

   task automatic wait_read0();
      int c = 0;
      while (ctrl0() != W_RD && c < 300) begin @(negedge clk); c++; end
      chk("reach_read", {27'd0, ctrl0()}, {27'd0, W_RD});
   endtask

   task automatic chk_reset0(input string nm);
      chk({nm, "_ctrl"}, {27'd0, ctrl0()}, 32'd0);
      chk({nm, "_busy_dv_err"}, {29'd0, b0.busy, b0.data_valid, b0.err}, 32'd0);
      chk({nm, "_data_out"}, {24'd0, b0.data_out}, 32'd0);
      chk({nm, "_addr_reg"}, {17'd0, b0.i2c_address, b0.i2c_register}, {17'd0, 7'h70, 8'hB2});
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int cnt;
      int busy_seen;
      b0.enable = 1'b1; b0.trig = 1'b0; b0.i2c_ack = 1'b0; b0.i2c_nack = 1'b0;
      b0.i2c_rdy = 1'b0; b0.i2c_out = 8'h00;
      b1.enable = 1'b1; b1.trig = 1'b0; b1.i2c_ack = 1'b0; b1.i2c_nack = 1'b0;
      b1.i2c_rdy = 1'b0; b1.i2c_out = 8'h00;
      #1 rst0 = 1'b0; rst1 = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset0("reset");
      chk("reset_dut1_busy", {31'd0, b1.busy}, 32'd0);
      rst0 = 1'b1;
      repeat (2) @(negedge clk);
      chk("no_auto_launch", {31'd0, b0.busy}, 32'd0);

      // Normal read returning 0xF0.
      rsp_q.push_back('{R_OK, 8'hF0});
      ev0_q.push_back('{1'b0, 8'hF0});
      seq_q.push_back(mk_seq(5, W_AW, W_RW, W_RS, W_RD, W_ST, 20));
      trig0();
      chk("busy_after_trig", {31'd0, b0.busy}, 32'd1);
      wait_idle0(200);
      repeat (3) @(negedge clk);
      chk("data_out_hold", {24'd0, b0.data_out}, 32'hF0);

      // NACK on the register byte.
      rsp_q.push_back('{R_NACK_REG, 8'h00});
      ev0_q.push_back('{1'b1, 8'hF0});
      seq_q.push_back(mk_seq(3, W_AW, W_RW, W_ST, 5'd0, 5'd0, 20));
      trig0();
      wait_idle0(200);

      // Responses while idle must be ignored.
      b0.i2c_out = 8'h11;
      p0(1'b1, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      chk("idle_ignore_busy", {31'd0, b0.busy}, 32'd0);
      chk("idle_ignore_data", {24'd0, b0.data_out}, 32'hF0);

      // ack and nack together count as NACK.
      rsp_q.push_back('{R_BOTH_ADDR, 8'h00});
      ev0_q.push_back('{1'b1, 8'hF0});
      seq_q.push_back(mk_seq(2, W_AW, W_ST, 5'd0, 5'd0, 5'd0, 20));
      trig0();
      wait_idle0(200);

      // Silent slave: err TIMEOUT cycles after ADDR_W entry.
      rsp_q.push_back('{R_SILENT, 8'h00});
      ev0_q.push_back('{1'b1, 8'hF0});
      seq_q.push_back(mk_seq(2, W_AW, W_ST, 5'd0, 5'd0, 5'd0, 20));
      trig0();
      chk("timeout_start_seen", {31'd0, b0.i2c_start}, 32'd1);
      cnt = 0;
      while (!b0.err && cnt < 5000) begin @(negedge clk); cnt++; end
      chk("timeout_cycles", cnt, 32'd4000);
      wait_idle0(200);

      // Three extra trigs while busy yield one pending read; enable drop mid-read.
      rsp_q.push_back('{R_OK, 8'h5A});
      rsp_q.push_back('{R_OK, 8'hA5});
      ev0_q.push_back('{1'b0, 8'h5A});
      ev0_q.push_back('{1'b0, 8'hA5});
      seq_q.push_back(mk_seq(5, W_AW, W_RW, W_RS, W_RD, W_ST, 20));
      seq_q.push_back(mk_seq(5, W_AW, W_RW, W_RS, W_RD, W_ST, 20));
      trig0();
      for (int i = 0; i < 3; i++) begin @(negedge clk); trig0(); end
      wait_idle0(200);
      wait_read0();
      b0.enable = 1'b0;
      wait_idle0(200);
      busy_seen = 0;
      repeat (60) begin @(negedge clk); if (b0.busy) busy_seen++; end
      chk("no_third_txn", busy_seen, 32'd0);
      b0.enable = 1'b1;

      // Asynchronous reset during READ with a pending request.
      rsp_q.push_back('{R_OK, 8'h77});
      seq_q.push_back(mk_seq(4, W_AW, W_RW, W_RS, W_RD, 5'd0, 0));
      trig0();
      @(negedge clk);
      trig0();
      wait_read0();
      #2 rst0 = 1'b0;
      #1 chk_reset0("async_reset");
      repeat (2) @(negedge clk);
      rst0 = 1'b1;
      busy_seen = 0;
      repeat (30) begin @(negedge clk); if (b0.busy) busy_seen++; end
      chk("pending_cleared", busy_seen, 32'd0);

      // Periodic mode on dut1: 50 idle cycles between reads.
      ev1_q.push_back(8'hA0);
      ev1_q.push_back(8'hA1);
      ev1_q.push_back(8'hA2);
      rst1 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cnt = 0;
         while (!b1.i2c_start && cnt < 200) begin @(negedge clk); cnt++; end
         chk("dut1_launch", {31'd0, b1.i2c_start}, 32'd1);
         if (k == 2) b1.enable = 1'b0;
         cnt = 0;
         while (b1.busy && cnt < 200) begin @(negedge clk); cnt++; end
         chk("dut1_idle", {31'd0, b1.busy}, 32'd0);
         if (k < 2) begin
            cnt = 0;
            while (!b1.i2c_start && cnt < 200) begin @(negedge clk); cnt++; end
            chk("dut1_idle_gap", cnt, 32'd50);
         end
      end
      busy_seen = 0;
      repeat (80) begin @(negedge clk); if (b1.busy) busy_seen++; end
      chk("dut1_stays_idle", busy_seen, 32'd0);
      chk("dut1_reads", dv1_cnt, 32'd3);
      chk("dut1_err_pulses", err1_cnt, 32'd0);

      chk("ev0_drained", ev0_q.size(), 32'd0);
      chk("ev1_drained", ev1_q.size(), 32'd0);
      chk("seq_drained", seq_q.size(), 32'd0);
      chk("rsp_drained", rsp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
